// File: rtl/pc_r32i_pkg.sv
// Shared RV32I branch condition codes; values match the B-type funct3 field.
package pc_r32i_pkg;

  typedef logic [2:0] branch_t;

  localparam branch_t BEQ  = 3'b000;
  localparam branch_t BNEQ = 3'b001;
  localparam branch_t BLT  = 3'b100;
  localparam branch_t BGE  = 3'b101;
  localparam branch_t BLTU = 3'b110;
  localparam branch_t BGEU = 3'b111;

endpackage

// File: rtl/pc_r32i_branch_cond.sv
// Selects the comparator flag named by the branch code; purely combinational,
// no flow control. Codes 3'b010/3'b011 never select a flag.
module branch_cond_r32i
  import pc_r32i_pkg::*;
(
  input  logic [2:0] branch_type,
  input  logic       EQ,
  input  logic       NE,
  input  logic       LT,
  input  logic       LTU,
  input  logic       GE,
  input  logic       GEU,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_t'(branch_type))
      BEQ:     cond = EQ;
      BNEQ:    cond = NE;
      BLT:     cond = LT;
      BGE:     cond = GE;
      BLTU:    cond = LTU;
      BGEU:    cond = GEU;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_r32i.sv
// RV32I program counter: steps by STEP or loads a branch/jump target each cycle.
// One-cycle latency from sampled controls to ProgAddr; no stall, advances every edge.
module pc_r32i
  import pc_r32i_pkg::*;
#(
  parameter int               dataW      = 32,
  parameter logic [dataW-1:0] RESET_ADDR = '0,
  parameter int               STEP       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             EQ,
  input  logic             NE,
  input  logic             LT,
  input  logic             LTU,
  input  logic             GE,
  input  logic             GEU,
  input  logic             TestBranch,
  input  logic [2:0]       PCBranchType,
  input  logic [dataW-1:0] BranchAddr,
  input  logic             AlwaysBranch,
  input  logic             AbsoluteBranch,
  output logic [dataW-1:0] ProgAddr
);

  logic             cond;
  logic             take;
  logic [dataW-1:0] target;
  logic [dataW-1:0] seq_addr;

  branch_cond_r32i u_cond (
    .branch_type (PCBranchType),
    .EQ          (EQ),
    .NE          (NE),
    .LT          (LT),
    .LTU         (LTU),
    .GE          (GE),
    .GEU         (GEU),
    .cond        (cond)
  );

  assign take = AlwaysBranch | (TestBranch & cond);

  // Absolute targets follow the JALR rule of clearing bit 0; relative sums wrap silently.
  assign target   = AbsoluteBranch ? {BranchAddr[dataW-1:1], 1'b0}
                                   : ProgAddr + BranchAddr;
  assign seq_addr = ProgAddr + dataW'(STEP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ProgAddr <= RESET_ADDR;
    end else begin
      ProgAddr <= take ? target : seq_addr;
    end
  end

endmodule

// File: tb/tb_pc_r32i.sv
// Directed-vector bench: stimulus pushes hand-computed PC values, a monitor pops and compares.
module tb_pc_r32i;
  import pc_r32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        EQ = 0, NE = 0, LT = 0, LTU = 0, GE = 0, GEU = 0;
  logic        TestBranch = 0;
  logic [2:0]  PCBranchType = 3'b000;
  logic [31:0] BranchAddr = '0;
  logic        AlwaysBranch = 0;
  logic        AbsoluteBranch = 0;
  logic [31:0] ProgAddr;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  pc_r32i #(.dataW(32), .RESET_ADDR(32'h0), .STEP(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .EQ             (EQ),
    .NE             (NE),
    .LT             (LT),
    .LTU            (LTU),
    .GE             (GE),
    .GEU            (GEU),
    .TestBranch     (TestBranch),
    .PCBranchType   (PCBranchType),
    .BranchAddr     (BranchAddr),
    .AlwaysBranch   (AlwaysBranch),
    .AbsoluteBranch (AbsoluteBranch),
    .ProgAddr       (ProgAddr)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: ProgAddr=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // flags = {EQ,NE,LT,LTU,GE,GEU}
  task automatic drive(input logic ab, input logic abs_b, input logic tb_b,
                       input logic [2:0] bt, input logic [5:0] flags,
                       input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clock);
    reset          = 1'b0;
    AlwaysBranch   = ab;
    AbsoluteBranch = abs_b;
    TestBranch     = tb_b;
    PCBranchType   = bt;
    {EQ, NE, LT, LTU, GE, GEU} = flags;
    BranchAddr     = addr;
    exp_q.push_back(exp);
  endtask

  // Monitor: the PC presents a new value after every non-reset rising edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_seq", ProgAddr, e);
      end
    end
  end

  initial begin
    #1;
    check("reset_now", ProgAddr, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold", ProgAddr, 32'h0);

    drive(0, 0, 0, BEQ, 6'b000000, 32'd0, 32'd4);
    drive(0, 0, 0, BEQ, 6'b000000, 32'd0, 32'd8);
    drive(0, 0, 0, BEQ, 6'b000000, 32'd0, 32'd12);
    drive(1, 0, 0, BEQ, 6'b000000, 32'd64, 32'd76);
    drive(1, 0, 0, BEQ, 6'b000000, 32'd64, 32'd140);
    drive(1, 1, 0, BEQ, 6'b000000, 32'd64, 32'd64);
    drive(1, 1, 0, BEQ, 6'b000000, 32'd64, 32'd64);
    drive(1, 1, 0, BEQ, 6'b000000, 32'd65, 32'd64);
    drive(0, 0, 1, BEQ,  6'b000000, 32'd64, 32'd68);
    drive(0, 0, 1, BEQ,  6'b100000, 32'd64, 32'd132);
    drive(0, 0, 1, BNEQ, 6'b000000, 32'd64, 32'd136);
    drive(0, 0, 1, BNEQ, 6'b010000, 32'd64, 32'd200);
    drive(0, 0, 1, BLT,  6'b001000, 32'd64, 32'd264);
    drive(0, 0, 1, BLT,  6'b110111, 32'd64, 32'd268);
    drive(0, 0, 1, BGE,  6'b000010, 32'd64, 32'd332);
    drive(0, 0, 1, BGE,  6'b111101, 32'd64, 32'd336);
    drive(0, 0, 1, BLTU, 6'b000100, 32'd64, 32'd400);
    drive(0, 0, 1, BLTU, 6'b111011, 32'd64, 32'd404);
    drive(0, 0, 1, BGEU, 6'b000001, 32'd64, 32'd468);
    drive(0, 0, 1, BGEU, 6'b111110, 32'd64, 32'd472);
    drive(0, 0, 1, 3'b010, 6'b111111, 32'd64, 32'd476);
    drive(0, 0, 1, 3'b011, 6'b111111, 32'd64, 32'd480);
    // AlwaysBranch overrides a failing condition; absolute with no take is inert
    drive(1, 0, 1, BEQ, 6'b000000, 32'd16, 32'd496);
    drive(0, 1, 0, BEQ, 6'b111111, 32'd64, 32'd500);
    drive(1, 1, 0, BEQ, 6'b000000, 32'd100, 32'd100);
    drive(1, 0, 0, BEQ, 6'b000000, 32'hFFFFFFF8, 32'd92);
    drive(0, 0, 1, BEQ, 6'b110000, 32'hFFFFFFF8, 32'd84);
    drive(1, 1, 0, BEQ, 6'b000000, 32'hFFFFFFFC, 32'hFFFFFFFC);
    drive(0, 0, 0, BEQ, 6'b000000, 32'd0, 32'h0);
    drive(0, 0, 0, BEQ, 6'b000000, 32'd0, 32'd4);

    // Mid-cycle async reset with a pending jump
    @(negedge clock);
    AlwaysBranch = 1'b1;
    BranchAddr   = 32'd64;
    #2 reset = 1'b1;
    #1;
    check("reset_async", ProgAddr, 32'h0);
    @(posedge clock);
    #1;
    check("reset_no_branch", ProgAddr, 32'h0);
    drive(0, 0, 0, BEQ, 6'b000000, 32'd64, 32'd4);
    drive(0, 0, 0, BEQ, 6'b000000, 32'd64, 32'd8);

    repeat (2) @(posedge clock);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_r32i.md
Name: pc_r32i

Overview:
- RV32I program counter with branch/jump target selection.
- Holds the current instruction byte address `ProgAddr`. Each clock, the counter either steps by 4 or loads a branch/jump target.
- The decoder drives the branch controls; the ALU comparator drives the condition flags.
- Sits between the control/ALU stage and instruction memory.

Parameters:
- dataW, 32, address/data width in bits.
- RESET_ADDR, 0, value loaded into `ProgAddr` on reset.
- STEP, 4, byte increment for sequential fetch.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces `ProgAddr` to RESET_ADDR.
- EQ  input  1  comparator: operands equal.
- NE  input  1  comparator: operands not equal.
- LT  input  1  comparator: signed less-than.
- LTU  input  1  comparator: unsigned less-than.
- GE  input  1  comparator: signed greater-or-equal.
- GEU  input  1  comparator: unsigned greater-or-equal.
- TestBranch  input  1  conditional branch instruction active.
- PCBranchType  input  3  condition selector, uses the shared branch codes.
- BranchAddr  input  dataW  signed branch offset, or absolute target.
- AlwaysBranch  input  1  unconditional jump (JAL/JALR).
- AbsoluteBranch  input  1  target is `BranchAddr` itself rather than `ProgAddr` + `BranchAddr`.
- ProgAddr  output  dataW  current program address (registered).

Behaviour:
- Reset:
  - While reset=1, `ProgAddr` = RESET_ADDR immediately (asynchronous) and holds.
  - The first update occurs on the first rising clock edge after reset deasserts.
  - Reset mid-operation discards any pending branch.
- Condition select (combinational `cond`), codes equal RV32I funct3:
  - BEQ=3'b000 -> EQ
  - BNEQ=3'b001 -> NE
  - BLT=3'b100 -> LT
  - BGE=3'b101 -> GE
  - BLTU=3'b110 -> LTU
  - BGEU=3'b111 -> GEU
  - Unused codes 3'b010 and 3'b011 -> cond=0 (never taken).
- Take decision: `take` = AlwaysBranch | (TestBranch & cond). AlwaysBranch takes priority and ignores PCBranchType and the flags.
- Target:
  - AbsoluteBranch=1 -> `BranchAddr` with bit 0 cleared (JALR rule).
  - AbsoluteBranch=0 -> `ProgAddr` + `BranchAddr`, signed offset in two's complement.
- Next value each rising edge: `ProgAddr` <= take ? target : `ProgAddr` + STEP.
- AbsoluteBranch with take=0 has no effect.
- Arithmetic: all sums are modulo 2^dataW. No overflow detection; wrap-around is silent (e.g. 32'hFFFFFFFC + 4 -> 0).
- Latency: one cycle. Inputs sampled at edge N determine `ProgAddr` after edge N.
- No stall input; the PC advances every cycle.
- Flags may be inconsistent (e.g. EQ=NE=1). Only the selected flag matters.
- No alignment checks, apart from the bit-0 clear on absolute targets.

Decomposition:
- Shared package/include (branchcodes):
  - the six 3-bit branch code constants BEQ, BNEQ, BLT, BGE, BLTU, BGEU;
  - a typedef for the 3-bit branch type.
- One natural sub-module: branch_cond_r32i, a combinational mux from PCBranchType plus the six flags to `cond`.
- The register and adder stay in the top module.

Test Plan:
- Reset pulse, all controls 0 -> `ProgAddr`=0 during reset, then 4, 8, 12 on successive edges.
- From `ProgAddr`=12, AlwaysBranch=1, `BranchAddr`=64 for 2 cycles -> 76, then 140.
- Add AbsoluteBranch=1 with `BranchAddr`=64 -> 64 on every edge. Then `BranchAddr`=65 -> 64 (bit 0 cleared).
- TestBranch=1, PCBranchType=BEQ, EQ=0, `BranchAddr`=64 -> +4 step. Set EQ=1 -> `ProgAddr`+64.
  - Switch to BNEQ with NE=0 -> +4.
  - NE=1 -> +64.
- Each of BLT/BGE/BLTU/BGEU with only its own flag set -> taken. With only other flags set -> +4. Code 3'b010 with all flags=1 -> +4.
- Boundaries:
  - Negative offset `BranchAddr`=-8 at `ProgAddr`=100 -> 92.
  - 32'hFFFFFFFC + 4 -> 0.
  - Async reset asserted mid-cycle while AlwaysBranch=1 -> 0 immediately, no branch taken.
